uart_rx_param: RTL and testbench

//  Parametrised successor to the fixed 8N1 receiver: UART RX with configurable data width, parity and stop bits.

---
 rtl/uart_rx_param.sv | 156 +++++++++++++++
 tb/tb_uart_rx_param.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// UART receiver with configurable data width, parity and stop bits.
// Synchronises rxd, majority-votes each bit sample and rejects false starts.
// Ports:
//   clk, reset      system clock, synchronous active-low reset
//   rxd             asynchronous serial line, idle high
//   out_data        received word, LSB = first data bit on the line
//   out_valid       out_data and error flags valid
//   out_ready       consumer accepts the word when out_valid && out_ready
//   parity_err      parity mismatch on the held word (qualified by out_valid)
//   frame_err       a stop bit sampled 0 (qualified by out_valid)
//   overrun_err     one-cycle pulse: finished frame dropped, output still full
//   rx_busy         receiver is inside a frame
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 rx_busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] D_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] S_LAST = 4'(STOP_BITS - 1);
    localparam logic ODD = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_n;

    logic                 rxd_m, rxd_s;
    logic [2:0]           hist;
    logic                 vote;
    logic [TW-1:0]        timer;
    logic [3:0]           cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 stop_bad;
    logic                 at_half, at_end;
    logic                 complete;

    // hist[0] is the previous rxd_s value, so hist[0] && !rxd_s is a falling edge
    assign vote    = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    assign at_half = (timer == T_HALF);
    assign at_end  = (timer == T_LAST);
    assign rx_busy = (state != IDLE);

    always_comb begin
        state_n  = state;
        complete = 1'b0;
        unique case (state)
            IDLE: begin
                if (hist[0] && !rxd_s) state_n = START;
            end
            START: begin
                if (at_half) state_n = vote ? IDLE : DATA;
            end
            DATA: begin
                if (at_end && cnt == D_LAST)
                    state_n = (PARITY_MODE != 0) ? PARITY : STOP;
            end
            PARITY: begin
                if (at_end) state_n = STOP;
            end
            STOP: begin
                if (at_end && cnt == S_LAST) begin
                    state_n  = IDLE;
                    complete = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            rxd_m       <= 1'b1;
            rxd_s       <= 1'b1;
            hist        <= 3'b111;
            timer       <= '0;
            cnt         <= '0;
            shreg       <= '0;
            par_bad     <= 1'b0;
            stop_bad    <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            hist  <= {hist[1:0], rxd_s};
            state <= state_n;

            if (state_n != state || state == IDLE || at_end)
                timer <= '0;
            else
                timer <= timer + 1'b1;

            if (state_n != state)
                cnt <= '0;
            else if (at_end && (state == DATA || state == STOP))
                cnt <= cnt + 1'b1;

            // LSB arrives first, so each new bit enters at the top
            if (state == DATA && at_end)
                shreg <= {vote, shreg[DATA_BITS-1:1]};

            if (state == START) begin
                par_bad  <= 1'b0;
                stop_bad <= 1'b0;
            end
            if (state == PARITY && at_end)
                par_bad <= ((^shreg) ^ vote) != ODD;
            if (state == STOP && at_end && !vote)
                stop_bad <= 1'b1;

            overrun_err <= 1'b0;
            if (complete) begin
                if (!out_valid || out_ready) begin
                    out_data   <= shreg;
                    parity_err <= par_bad;
                    // include the stop sample taken this cycle
                    frame_err  <= stop_bad | ~vote;
                    out_valid  <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid  <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 8E1, 7O2) at 16 clks/bit.
// Expected words are queued when a frame is driven and popped when one arrives.
module tb_uart_rx_param;

    localparam int C = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic rxd0 = 1'b1, rxd1 = 1'b1, rxd2 = 1'b1;
    logic rdy0 = 1'b0, rdy1 = 1'b0, rdy2 = 1'b0;
    logic [7:0] data0, data1;
    logic [6:0] data2;
    logic val0, val1, val2;
    logic pe0, pe1, pe2;
    logic fe0, fe1, fe2;
    logic ovr0, ovr1, ovr2;
    logic busy0, busy1, busy2;

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .rxd(rxd0), .out_data(data0), .out_valid(val0),
        .out_ready(rdy0), .parity_err(pe0), .frame_err(fe0), .overrun_err(ovr0),
        .rx_busy(busy0));

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .rxd(rxd1), .out_data(data1), .out_valid(val1),
        .out_ready(rdy1), .parity_err(pe1), .frame_err(fe1), .overrun_err(ovr1),
        .rx_busy(busy1));

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .rxd(rxd2), .out_data(data2), .out_valid(val2),
        .out_ready(rdy2), .parity_err(pe2), .frame_err(fe2), .overrun_err(ovr2),
        .rx_busy(busy2));

    int npass = 0;
    int ntotal = 0;
    logic [10:0] exp_q[$];
    int ovr_cnt0 = 0;
    int busy_cnt0 = 0;

    always @(negedge clk) begin
        if (ovr0) ovr_cnt0++;
        if (busy0) busy_cnt0++;
    end

    task automatic drive(input int w, input logic v);
        case (w)
            0: rxd0 = v;
            1: rxd1 = v;
            default: rxd2 = v;
        endcase
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int w, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            drive(w, bits[i]);
            hold(C);
        end
    endtask

    task automatic set_ready(input int w, input logic v);
        case (w)
            0: rdy0 = v;
            1: rdy1 = v;
            default: rdy2 = v;
        endcase
    endtask

    // wait (bounded) for out_valid, capture, then accept with a 1-cycle ready
    task automatic take(input int w, output logic [8:0] d, output logic pe,
                        output logic fe, output bit ok);
        ok = 1'b0;
        d = '0;
        pe = 1'b0;
        fe = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            case (w)
                0: if (val0) begin ok = 1'b1; d = {1'b0, data0}; pe = pe0; fe = fe0; end
                1: if (val1) begin ok = 1'b1; d = {1'b0, data1}; pe = pe1; fe = fe1; end
                default: if (val2) begin ok = 1'b1; d = {2'b0, data2}; pe = pe2; fe = fe2; end
            endcase
            if (!ok) @(negedge clk);
        end
        if (ok) begin
            set_ready(w, 1'b1);
            @(negedge clk);
            set_ready(w, 1'b0);
        end
    endtask

    function automatic logic [15:0] f8n1(input logic [7:0] d, input logic stop);
        return {6'b0, stop, d, 1'b0};
    endfunction

    logic [8:0] d;
    logic pe, fe;
    bit ok;
    logic [10:0] e;

    task automatic test_reset();
        reset = 1'b0;
        hold(3);
        ntotal++;
        if (data0 !== 8'h00) $display("FAIL reset_data got %h want 00", data0); else npass++;
        ntotal++;
        if (val0 !== 1'b0) $display("FAIL reset_valid got %b want 0", val0); else npass++;
        ntotal++;
        if (pe0 !== 1'b0 || fe0 !== 1'b0) $display("FAIL reset_flags got %b%b want 00", pe0, fe0); else npass++;
        ntotal++;
        if (ovr0 !== 1'b0) $display("FAIL reset_ovr got %b want 0", ovr0); else npass++;
        ntotal++;
        if (busy0 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy0); else npass++;
        reset = 1'b1;
        hold(5);
    endtask

    task automatic test_basic();
        exp_q.push_back({2'b00, 9'h0A5});
        send(0, f8n1(8'hA5, 1'b1), 10);
        hold(4);
        take(0, d, pe, fe, ok);
        e = exp_q.pop_front();
        ntotal++;
        if (!ok || d !== e[8:0]) $display("FAIL basic_data got %h want %h ok=%0d", d, e[8:0], ok); else npass++;
        ntotal++;
        if (pe !== e[10] || fe !== e[9]) $display("FAIL basic_flags got %b%b want %b%b", pe, fe, e[10], e[9]); else npass++;
        ntotal++;
        if (val0 !== 1'b0) $display("FAIL basic_valid_drop got %b want 0", val0); else npass++;
        ntotal++;
        if (busy0 !== 1'b0) $display("FAIL basic_busy got %b want 0", busy0); else npass++;
    endtask

    task automatic test_parity();
        exp_q.push_back({2'b00, 9'h007});
        send(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        hold(4);
        take(1, d, pe, fe, ok);
        e = exp_q.pop_front();
        ntotal++;
        if (!ok || d !== e[8:0]) $display("FAIL par_good_data got %h want %h ok=%0d", d, e[8:0], ok); else npass++;
        ntotal++;
        if (pe !== e[10]) $display("FAIL par_good_pe got %b want %b", pe, e[10]); else npass++;
        exp_q.push_back({2'b10, 9'h007});
        send(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        hold(4);
        take(1, d, pe, fe, ok);
        e = exp_q.pop_front();
        ntotal++;
        if (!ok || d !== e[8:0]) $display("FAIL par_bad_data got %h want %h ok=%0d", d, e[8:0], ok); else npass++;
        ntotal++;
        if (pe !== e[10] || fe !== e[9]) $display("FAIL par_bad_flags got %b%b want %b%b", pe, fe, e[10], e[9]); else npass++;
    endtask

    task automatic test_false_start();
        int b;
        b = busy_cnt0;
        drive(0, 1'b0);
        hold(5);
        drive(0, 1'b1);
        hold(30);
        ntotal++;
        if (busy_cnt0 == b) $display("FAIL fs_busy_pulse got 0 busy cycles want >0"); else npass++;
        ntotal++;
        if (busy0 !== 1'b0) $display("FAIL fs_busy_idle got %b want 0", busy0); else npass++;
        ntotal++;
        if (val0 !== 1'b0) $display("FAIL fs_no_valid got %b want 0", val0); else npass++;
        exp_q.push_back({2'b00, 9'h03C});
        send(0, f8n1(8'h3C, 1'b1), 10);
        hold(4);
        take(0, d, pe, fe, ok);
        e = exp_q.pop_front();
        ntotal++;
        if (!ok || d !== e[8:0] || pe !== e[10] || fe !== e[9])
            $display("FAIL fs_next_frame got %h/%b%b want %h/%b%b ok=%0d", d, pe, fe, e[8:0], e[10], e[9], ok);
        else npass++;
    endtask

    task automatic test_frame_err();
        int b;
        exp_q.push_back({2'b01, 9'h055});
        send(0, f8n1(8'h55, 1'b0), 10);
        hold(40);
        take(0, d, pe, fe, ok);
        e = exp_q.pop_front();
        ntotal++;
        if (!ok || d !== e[8:0]) $display("FAIL fe_data got %h want %h ok=%0d", d, e[8:0], ok); else npass++;
        ntotal++;
        if (fe !== e[9] || pe !== e[10]) $display("FAIL fe_flags got %b%b want %b%b", pe, fe, e[10], e[9]); else npass++;
        b = busy_cnt0;
        hold(40);
        ntotal++;
        if (busy_cnt0 != b) $display("FAIL fe_break_retrigger got %0d busy cycles want 0", busy_cnt0 - b); else npass++;
        ntotal++;
        if (val0 !== 1'b0) $display("FAIL fe_break_valid got %b want 0", val0); else npass++;
        drive(0, 1'b1);
        hold(20);
    endtask

    task automatic test_overrun();
        int o;
        o = ovr_cnt0;
        exp_q.push_back({2'b00, 9'h011});
        send(0, f8n1(8'h11, 1'b1), 10);
        send(0, f8n1(8'h22, 1'b1), 10);
        hold(4);
        ntotal++;
        if (ovr_cnt0 - o != 1) $display("FAIL ovr_pulse got %0d cycles want 1", ovr_cnt0 - o); else npass++;
        ntotal++;
        if (data0 !== 8'h11 || val0 !== 1'b1) $display("FAIL ovr_hold got %h v=%b want 11 v=1", data0, val0); else npass++;
        take(0, d, pe, fe, ok);
        e = exp_q.pop_front();
        ntotal++;
        if (!ok || d !== e[8:0] || pe !== e[10] || fe !== e[9])
            $display("FAIL ovr_accept got %h/%b%b want %h/%b%b ok=%0d", d, pe, fe, e[8:0], e[10], e[9], ok);
        else npass++;
        ntotal++;
        if (val0 !== 1'b0) $display("FAIL ovr_valid_drop got %b want 0", val0); else npass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        v = 8'hC3;
        drive(0, 1'b0);
        hold(C);
        for (int i = 0; i < 4; i++) begin
            drive(0, v[i]);
            hold(C);
        end
        drive(0, v[4]);
        hold(8);
        ntotal++;
        if (busy0 !== 1'b1) $display("FAIL mid_busy_before got %b want 1", busy0); else npass++;
        reset = 1'b0;
        hold(1);
        ntotal++;
        if (busy0 !== 1'b0 || val0 !== 1'b0) $display("FAIL mid_reset_ctl got b=%b v=%b want 0 0", busy0, val0); else npass++;
        ntotal++;
        if (data0 !== 8'h00 || pe0 !== 1'b0 || fe0 !== 1'b0 || ovr0 !== 1'b0)
            $display("FAIL mid_reset_out got %h %b%b%b want 00 000", data0, pe0, fe0, ovr0);
        else npass++;
        reset = 1'b1;
        drive(0, 1'b1);
        hold(40);
        ntotal++;
        if (busy0 !== 1'b0 || val0 !== 1'b0) $display("FAIL mid_quiet got b=%b v=%b want 0 0", busy0, val0); else npass++;
        exp_q.push_back({2'b00, 9'h0C3});
        send(0, f8n1(8'hC3, 1'b1), 10);
        hold(4);
        take(0, d, pe, fe, ok);
        e = exp_q.pop_front();
        ntotal++;
        if (!ok || d !== e[8:0] || pe !== e[10] || fe !== e[9])
            $display("FAIL mid_next_frame got %h/%b%b want %h/%b%b ok=%0d", d, pe, fe, e[8:0], e[10], e[9], ok);
        else npass++;
    endtask

    task automatic test_7o2();
        exp_q.push_back({2'b00, 9'h025});
        send(2, {5'b0, 1'b1, 1'b1, 1'b0, 7'h25, 1'b0}, 11);
        hold(4);
        take(2, d, pe, fe, ok);
        e = exp_q.pop_front();
        ntotal++;
        if (!ok || d !== e[8:0]) $display("FAIL o2_good_data got %h want %h ok=%0d", d, e[8:0], ok); else npass++;
        ntotal++;
        if (pe !== e[10] || fe !== e[9]) $display("FAIL o2_good_flags got %b%b want %b%b", pe, fe, e[10], e[9]); else npass++;
        ntotal++;
        if (busy2 !== 1'b0) $display("FAIL o2_busy got %b want 0", busy2); else npass++;
        exp_q.push_back({2'b11, 9'h05A});
        send(2, {5'b0, 1'b0, 1'b1, 1'b0, 7'h5A, 1'b0}, 11);
        drive(2, 1'b1);
        hold(4);
        take(2, d, pe, fe, ok);
        e = exp_q.pop_front();
        ntotal++;
        if (!ok || d !== e[8:0]) $display("FAIL o2_bad_data got %h want %h ok=%0d", d, e[8:0], ok); else npass++;
        ntotal++;
        if (pe !== e[10] || fe !== e[9]) $display("FAIL o2_bad_flags got %b%b want %b%b", pe, fe, e[10], e[9]); else npass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_7o2();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
